// File: rtl/hazard_ctrl_idex.sv
// ============================================================================
// Module      : hazard_ctrl_idex
// Description : Load-use / branch-flush / memory-busy hazard controller for
//               the ID/EX boundary. Optional perf counters are enabled by the
//               HAZARD_PERF_CNT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module hazard_ctrl_idex #(
    parameter int LOAD_STALL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        idex_mem_read,
    input  logic [2:0]  idex_rt,
    input  logic [2:0]  ifid_rs,
    input  logic [2:0]  ifid_rt,
    input  logic        ifid_uses_rs,
    input  logic        ifid_uses_rt,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        idex_write,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    localparam logic [0:0] S_RUN   = 1'b0;
    localparam logic [0:0] S_STALL = 1'b1;

    localparam logic       c_MULTI_STALL = (LOAD_STALL_CYCLES > 1);
    localparam logic [1:0] c_REM_INIT    = (LOAD_STALL_CYCLES > 1) ?
                                           2'(LOAD_STALL_CYCLES - 2) : 2'd0;

    logic [0:0] r_state;
    logic [1:0] r_rem;
    logic       w_hit;
    logic       w_stallCyc;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign w_hit = idex_mem_read && (idex_rt != 3'd0) &&
                   ((ifid_uses_rs && (ifid_rs == idex_rt)) ||
                    (ifid_uses_rt && (ifid_rt == idex_rt)));

    assign w_stallCyc = (r_state == S_STALL) || w_hit;

    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (rst) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write = 1'b0;
        end else if (ex_branch_taken) begin
            pc_write    = 1'b1;
            ifid_write  = 1'b1;
            idex_write  = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_stallCyc) begin
            idex_write  = 1'b1;
            idex_bubble = 1'b1;
        end else begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            idex_write = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
            r_rem   <= 2'd0;
        end else if (!mem_busy) begin
            if (ex_branch_taken) begin
                r_state <= S_RUN;
                r_rem   <= 2'd0;
            end else if (r_state == S_STALL) begin
                if (r_rem != 2'd0) begin
                    r_rem <= r_rem - 2'd1;
                end else begin
                    r_state <= S_RUN;
                end
            end else if (w_hit && c_MULTI_STALL) begin
                // detection cycle already counts as the first stall cycle
                r_state <= S_STALL;
                r_rem   <= c_REM_INIT;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stallCnt;
    logic [15:0] r_flushCnt;
    logic        w_stallEv;
    logic        w_flushEv;

    assign w_flushEv = !mem_busy && ex_branch_taken;
    assign w_stallEv = !mem_busy && !ex_branch_taken && w_stallCyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCnt <= 16'h0000;
            r_flushCnt <= 16'h0000;
        end else begin
            if (w_stallEv && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'h0001;
            end
            if (w_flushEv && (r_flushCnt != 16'hFFFF)) begin
                r_flushCnt <= r_flushCnt + 16'h0001;
            end
        end
    end

    assign stall_cnt = r_stallCnt;
    assign flush_cnt = r_flushCnt;
`else
    assign stall_cnt = 16'h0000;
    assign flush_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl_idex.sv
// ============================================================================
// Module      : tb_hazard_ctrl_idex
// Description : Scoreboard bench for hazard_ctrl_idex; three instances with
//               LOAD_STALL_CYCLES = 1, 2, 3 share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_ctrl_idex;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       idex_mem_read = 1'b0;
    logic [2:0] idex_rt = 3'd0;
    logic [2:0] ifid_rs = 3'd0;
    logic [2:0] ifid_rt = 3'd0;
    logic       ifid_uses_rs = 1'b0;
    logic       ifid_uses_rt = 1'b0;
    logic       ex_branch_taken = 1'b0;
    logic       mem_busy = 1'b0;

    // {pc_write, ifid_write, idex_write, ifid_flush, idex_bubble, stall_cnt, flush_cnt}
    logic [36:0] dutOut [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic        pcW, ifidW, idexW, flushO, bubbleO;
        logic [15:0] sCnt, fCnt;
        hazard_ctrl_idex #(.LOAD_STALL_CYCLES(g + 1)) u_dut (
            .clk             (clk),
            .rst             (rst),
            .idex_mem_read   (idex_mem_read),
            .idex_rt         (idex_rt),
            .ifid_rs         (ifid_rs),
            .ifid_rt         (ifid_rt),
            .ifid_uses_rs    (ifid_uses_rs),
            .ifid_uses_rt    (ifid_uses_rt),
            .ex_branch_taken (ex_branch_taken),
            .mem_busy        (mem_busy),
            .pc_write        (pcW),
            .ifid_write      (ifidW),
            .idex_write      (idexW),
            .ifid_flush      (flushO),
            .idex_bubble     (bubbleO),
            .stall_cnt       (sCnt),
            .flush_cnt       (fCnt)
        );
        assign dutOut[g] = {pcW, ifidW, idexW, flushO, bubbleO, sCnt, fCnt};
    end

    typedef struct {
        logic [36:0] e [3];
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cycNo    = 0;

    // Reference model: stall cycles still owed after the current one, and event counts
    int stallLeft [3] = '{0, 0, 0};
    int sCount    [3] = '{0, 0, 0};
    int fCount    [3] = '{0, 0, 0};

    task automatic step(input logic r, input logic mr, input logic [2:0] xrt,
                        input logic [2:0] rs, input logic [2:0] rt,
                        input logic urs, input logic urt,
                        input logic br, input logic busy);
        exp_t x;
        logic hit;
        logic [4:0] ctl;
        @(posedge clk);
        #1;
        rst = r; idex_mem_read = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
        ifid_uses_rs = urs; ifid_uses_rt = urt; ex_branch_taken = br; mem_busy = busy;
        hit = mr && (xrt != 3'd0) && ((urs && rs == xrt) || (urt && rt == xrt));
        for (int k = 0; k < 3; k++) begin
`ifdef HAZARD_PERF_CNT_EN
            x.e[k][31:0] = {sCount[k][15:0], fCount[k][15:0]};
`else
            x.e[k][31:0] = 32'h0;
`endif
            if (r) begin
                ctl = 5'b00011;
                stallLeft[k] = 0; sCount[k] = 0; fCount[k] = 0;
            end else if (busy) begin
                ctl = 5'b00000;
            end else if (br) begin
                ctl = 5'b11111;
                stallLeft[k] = 0;
                if (fCount[k] < 65535) fCount[k]++;
            end else if (stallLeft[k] > 0 || hit) begin
                ctl = 5'b00101;
                if (sCount[k] < 65535) sCount[k]++;
                stallLeft[k] = (stallLeft[k] > 0) ? stallLeft[k] - 1 : k;
            end else begin
                ctl = 5'b11100;
            end
            x.e[k][36:32] = ctl;
        end
        x.cyc = cycNo;
        cycNo++;
        sb.push_back(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle the DUTs present a full output set mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dutOut[k] !== x.e[k]) begin
                    failures++;
                    $display("FAIL outputs lsc=%0d cycle=%0d got=%h expected=%h",
                             k + 1, x.cyc, dutOut[k], x.e[k]);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset and plain run
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // load-use on rs, then on rt
        step(0, 1, 3'd3, 3'd3, 3'd1, 1, 0, 0, 0);
        idle(4);
        step(0, 1, 3'd5, 3'd2, 3'd5, 0, 1, 0, 0);
        idle(4);
        // no hazard: r0 destination, or source not used
        step(0, 1, 3'd0, 3'd0, 3'd0, 1, 1, 0, 0);
        step(0, 1, 3'd3, 3'd3, 3'd3, 0, 0, 0, 0);
        idle(2);
        // branch together with a load-use hit
        step(0, 1, 3'd3, 3'd3, 3'd0, 1, 0, 1, 0);
        idle(2);
        // hit, then memory busy for 4 cycles from the second stall cycle
        step(0, 1, 3'd4, 3'd4, 3'd0, 1, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(4);
        // branch in the middle of a stall, then reset mid-stall
        step(0, 1, 3'd6, 3'd6, 3'd0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 1, 3'd6, 3'd6, 3'd0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(3);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] xrt, rs, rt;
            xrt = 3'($urandom_range(0, 7));
            rs  = ($urandom_range(0, 1) == 1) ? xrt : 3'($urandom_range(0, 7));
            rt  = ($urandom_range(0, 2) == 0) ? xrt : 3'($urandom_range(0, 7));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, xrt, rs, rt,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 15);
        end
        // counter saturation
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65540; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 3'd2, 3'd2, 3'd0, 1, 0, 0, 0);
        idle(4);
        // drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_ctrl_idex.md
# hazard_ctrl_idex

Pipeline hazard controller for the 16-bit, 8-register pipelined core. Inspects the instruction held in the ID/EX register (EX stage) against the instruction in IF/ID, and drives write enables and bubble/flush controls back into the PC, IF/ID and ID/EX registers. A small FSM stretches load-use stalls to a configurable length and handles taken-branch flushes and memory-busy freezes.

## Interface
Parameters:
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard; legal 1..3

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- idex_mem_read  in  1  instruction in EX is a load (ID/EX M field read bit)
- idex_rt  in  3  load destination register in EX
- ifid_rs  in  3  source register A of instruction in ID
- ifid_rt  in  3  source register B of instruction in ID
- ifid_uses_rs  in  1  ID instruction reads rs
- ifid_uses_rt  in  1  ID instruction reads rt
- ex_branch_taken  in  1  branch resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; whole pipe must hold
- pc_write  out  1  PC load enable
- ifid_write  out  1  IF/ID load enable
- idex_write  out  1  ID/EX load enable
- ifid_flush  out  1  IF/ID loads NOP this edge
- idex_bubble  out  1  ID/EX loads zeroed WB/M/EX control this edge
- stall_cnt  out  16  load-use stall cycles, saturating
- flush_cnt  out  16  taken-branch flush events, saturating

## Operation
- States: RUN, STALL. Down-counter rem (2 bits).
- Hazard hit = idex_mem_read && idex_rt != 0 && ((ifid_uses_rs && ifid_rs == idex_rt) || (ifid_uses_rt && ifid_rt == idex_rt)). r0 is hardwired zero, never a hazard.
- Output priority per cycle, highest first:
  - rst: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=1, idex_bubble=1.
  - mem_busy: all writes 0, flush/bubble 0; FSM, rem, counters hold.
  - ex_branch_taken: pc_write=1, ifid_write=1, idex_write=1, ifid_flush=1, idex_bubble=1; next state RUN, rem=0; flush_cnt+1.
  - STALL, or RUN with hazard hit: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1, ifid_flush=0; stall_cnt+1.
  - Otherwise: pc_write=ifid_write=idex_write=1, flush/bubble 0.
- Transitions:
  - RUN + hit, LOAD_STALL_CYCLES>1: -> STALL, rem=LOAD_STALL_CYCLES-2. LOAD_STALL_CYCLES=1: stay RUN.
  - STALL, rem!=0: rem-1. STALL, rem==0: -> RUN.
  - Hazard detection is evaluated only in RUN; in STALL the ID/EX content is a bubble.
- Counters: 16-bit, saturate at 0xFFFF, no wrap.

## Timing
- All control outputs combinational from state, rem and inputs; state, rem, counters update on rising clk.
- Load-use stall: exactly LOAD_STALL_CYCLES consecutive cycles with pc_write=0, counting the detection cycle; pc_write=1 on the following cycle if no new event.
- Branch flush: single cycle, no state.
- mem_busy inside STALL extends the stall by the busy length; remaining stall count unchanged.
- Branch during STALL (illegal from the datapath, but defined): flush wins, FSM -> RUN.
- Reset mid-stall: RUN, rem=0, counters 0 on the next edge.
- Reset values: state RUN, rem 0, stall_cnt 0, flush_cnt 0.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt/flush_cnt registers present as above.
- Not defined: no counter flops; stall_cnt and flush_cnt tied to 16'h0000. Control behaviour identical.

## Test plan
- Reset 2 cycles -> ifid_flush=1, idex_bubble=1, all writes 0; after release, in RUN with no hazard -> pc_write=ifid_write=idex_write=1, counters 0.
- LOAD_STALL_CYCLES=2, idex_mem_read=1, idex_rt=3, ifid_rs=3, ifid_uses_rs=1 -> pc_write=0 for exactly 2 cycles, idex_bubble=1 both, stall_cnt=2.
- Same stimulus with idex_rt=0 or ifid_uses_rs=0 -> no stall, stall_cnt stays 0.
- ex_branch_taken=1 together with a load-use hit -> ifid_flush=1, idex_bubble=1, pc_write=1, stall_cnt unchanged, flush_cnt=1.
- LOAD_STALL_CYCLES=3, mem_busy=1 for 4 cycles starting second stall cycle -> all writes 0 during busy, total pc_write=0 span 7 cycles, stall_cnt=3.
- Preload via 65 540 branch flushes -> flush_cnt holds 0xFFFF; with HAZARD_PERF_CNT_EN undefined -> both counters read 0.
